// File: rtl/snake_food_manager.sv
// snake_food_manager: multi-slot apple manager for the snake game.
// Compares the head against every live food slot once per game tick, pulses
// add_cube on an eat and relocates the eaten slot with an LFSR-driven,
// rejection-sampled respawn sequencer.
// Optional build macro: FOOD_TIMEOUT_EN (uneaten food relocates after 1023 ticks).
module snake_food_manager #(
  parameter int unsigned X_W       = 7,
  parameter int unsigned Y_W       = 7,
  parameter int unsigned NUM_FOOD  = 2,
  parameter int unsigned X_MIN     = 3,
  parameter int unsigned X_MAX     = 60,
  parameter int unsigned Y_MIN     = 3,
  parameter int unsigned Y_MAX     = 50,
  parameter int unsigned INIT_X    = 24,
  parameter int unsigned INIT_Y    = 34,
  parameter int unsigned TICK_DIV  = 250000,
  parameter int unsigned MAX_TRIES = 64,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [X_W-1:0]          head_x,
  input  logic [Y_W-1:0]          head_y,
  output logic [NUM_FOOD*X_W-1:0] food_x,
  output logic [NUM_FOOD*Y_W-1:0] food_y,
  output logic [NUM_FOOD-1:0]     food_valid,
  output logic                    add_cube,
  output logic [1:0]              eaten_idx,
  output logic                    busy
);

  localparam int unsigned CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TRY_W     = $clog2(MAX_TRIES + 1);
  localparam int unsigned LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAW,
    S_TEST,
    S_COMMIT
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   count;
  logic [LFSR_W-1:0]  lfsr;
  logic [X_W-1:0]     slot_x [NUM_FOOD];
  logic [Y_W-1:0]     slot_y [NUM_FOOD];
  logic [NUM_FOOD-1:0] pending;
  logic [1:0]         sel, sel_n;
  logic [TRY_W-1:0]   tries, tries_n;
  logic [X_W-1:0]     cand_x, cand_x_n;
  logic [Y_W-1:0]     cand_y, cand_y_n;
  logic               busy_n;

  logic               tick_c;
  logic               hit_c;
  logic               eat_c;
  logic [1:0]         hit_idx_c;
  logic [1:0]         low_pend_c;
  logic               accept_c;
  logic               commit_c;
  logic [NUM_FOOD-1:0] timeout_c;

  // Game tick divider: runs only while the game is enabled.
  assign tick_c = enable && (count == CNT_W'(TICK_DIV - 1));

  // Tick counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (enable) begin
      count <= tick_c ? '0 : count + CNT_W'(1);
    end
  end

  // Free-running right-shift Galois LFSR, independent of enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? LFSR_MASK : '0);
    end
  end

  // Head-versus-food compare; iterating downward leaves the lowest hit index.
  always_comb begin
    hit_c     = 1'b0;
    hit_idx_c = '0;
    for (int i = NUM_FOOD - 1; i >= 0; i--) begin
      if (food_valid[i] && (slot_x[i] == head_x) && (slot_y[i] == head_y)) begin
        hit_c     = 1'b1;
        hit_idx_c = 2'(i);
      end
    end
  end

  assign eat_c = tick_c && hit_c;

  // Lowest-index slot waiting for a new position.
  always_comb begin
    low_pend_c = '0;
    for (int i = NUM_FOOD - 1; i >= 0; i--) begin
      if (pending[i]) begin
        low_pend_c = 2'(i);
      end
    end
  end

  // Candidate acceptance: inside playfield, off the head, off every live food.
  always_comb begin
    accept_c = (cand_x >= X_W'(X_MIN)) && (cand_x <= X_W'(X_MAX)) &&
               (cand_y >= Y_W'(Y_MIN)) && (cand_y <= Y_W'(Y_MAX)) &&
               !((cand_x == head_x) && (cand_y == head_y));
    for (int i = 0; i < NUM_FOOD; i++) begin
      if (food_valid[i] && (slot_x[i] == cand_x) && (slot_y[i] == cand_y)) begin
        accept_c = 1'b0;
      end
    end
  end

  // Respawn sequencer state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      sel    <= '0;
      tries  <= '0;
      cand_x <= '0;
      cand_y <= '0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      sel    <= sel_n;
      tries  <= tries_n;
      cand_x <= cand_x_n;
      cand_y <= cand_y_n;
      busy   <= busy_n;
    end
  end

  // Respawn next-state: draw, test, retry or fall back, then commit.
  always_comb begin
    state_n  = state;
    sel_n    = sel;
    tries_n  = tries;
    cand_x_n = cand_x;
    cand_y_n = cand_y;
    busy_n   = busy;
    commit_c = 1'b0;
    case (state)
      S_IDLE: begin
        busy_n = |pending;
        if (|pending) begin
          sel_n   = low_pend_c;
          tries_n = '0;
          state_n = S_DRAW;
        end
      end
      S_DRAW: begin
        cand_x_n = lfsr[X_W-1:0];
        cand_y_n = lfsr[LFSR_W-1 -: Y_W];
        state_n  = S_TEST;
      end
      S_TEST: begin
        if (accept_c) begin
          state_n = S_COMMIT;
        end else if (tries == TRY_W'(MAX_TRIES - 1)) begin
          cand_x_n = X_W'(X_MIN);
          cand_y_n = Y_W'(Y_MIN);
          state_n  = S_COMMIT;
        end else begin
          tries_n = tries + TRY_W'(1);
          state_n = S_DRAW;
        end
      end
      S_COMMIT: begin
        commit_c = 1'b1;
        state_n  = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

`ifdef FOOD_TIMEOUT_EN
  logic [9:0] age [NUM_FOOD];

  // Stale-food detect: eating the same slot in the same tick wins.
  always_comb begin
    timeout_c = '0;
    for (int i = 0; i < NUM_FOOD; i++) begin
      timeout_c[i] = tick_c && food_valid[i] && (age[i] == 10'd1023) &&
                     !(eat_c && (hit_idx_c == 2'(i)));
    end
  end

  // Per-slot age in ticks, restarted whenever the slot gets a new position.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_FOOD; i++) begin
        age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FOOD; i++) begin
        if ((commit_c && (sel == 2'(i))) || timeout_c[i]) begin
          age[i] <= '0;
        end else if (tick_c && food_valid[i]) begin
          age[i] <= age[i] + 10'd1;
        end
      end
    end
  end
`else
  assign timeout_c = '0;
`endif

  // Slot table, grow pulse and pending queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      add_cube   <= 1'b0;
      eaten_idx  <= '0;
      food_valid <= '1;
      pending    <= '0;
      for (int i = 0; i < NUM_FOOD; i++) begin
        slot_x[i] <= X_W'(INIT_X + 4 * i);
        slot_y[i] <= Y_W'(INIT_Y);
      end
    end else begin
      add_cube <= eat_c;
      if (eat_c) begin
        eaten_idx <= hit_idx_c;
      end
      for (int i = 0; i < NUM_FOOD; i++) begin
        if (commit_c && (sel == 2'(i))) begin
          slot_x[i]     <= cand_x;
          slot_y[i]     <= cand_y;
          food_valid[i] <= 1'b1;
          pending[i]    <= 1'b0;
        end else if ((eat_c && (hit_idx_c == 2'(i))) || timeout_c[i]) begin
          food_valid[i] <= 1'b0;
          pending[i]    <= 1'b1;
        end
      end
    end
  end

  // Flatten the slot table onto the renderer buses.
  for (genvar g = 0; g < NUM_FOOD; g++) begin : g_pack
    assign food_x[g*X_W +: X_W] = slot_x[g];
    assign food_y[g*Y_W +: Y_W] = slot_y[g];
  end

endmodule

// File: tb/tb_snake_food_manager.sv
// Directed bench for snake_food_manager: reset state, eat timing, enable
// freeze, respawn placement, reset during respawn and the fallback path.
module tb_snake_food_manager;

  logic        clk = 1'b0;
  logic        rst, enable;
  logic [6:0]  head_x, head_y;
  logic [13:0] food_x, food_y;
  logic [1:0]  food_valid;
  logic        add_cube, busy;
  logic [1:0]  eaten_idx;

  logic        rst2, enable2;
  logic [6:0]  head2_x, head2_y;
  logic [13:0] food2_x, food2_y;
  logic [1:0]  food2_valid;
  logic        add2_cube, busy2;
  logic [1:0]  eaten2_idx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  snake_food_manager #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .head_x(head_x), .head_y(head_y),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
    .add_cube(add_cube), .eaten_idx(eaten_idx), .busy(busy)
  );

  snake_food_manager #(.TICK_DIV(4), .X_MIN(5), .X_MAX(5), .Y_MIN(5), .Y_MAX(5)) dut2 (
    .clk(clk), .rst(rst2), .enable(enable2),
    .head_x(head2_x), .head_y(head2_y),
    .food_x(food2_x), .food_y(food2_y), .food_valid(food2_valid),
    .add_cube(add2_cube), .eaten_idx(eaten2_idx), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset-value checks shared by the power-up and mid-respawn reset cases.
  task automatic check_reset(input string tag);
    check({tag, "_food_x"}, 32'(food_x), 32'({7'd28, 7'd24}));
    check({tag, "_food_y"}, 32'(food_y), 32'({7'd34, 7'd34}));
    check({tag, "_valid"},  32'(food_valid), 32'd3);
    check({tag, "_add"},    32'(add_cube), 32'd0);
    check({tag, "_idx"},    32'(eaten_idx), 32'd0);
    check({tag, "_busy"},   32'(busy), 32'd0);
    check({tag, "_lfsr"},   32'(dut.lfsr), 32'hACE1);
  endtask

  logic       seen_add;
  logic       valid_ok;
  int         waited;
  int         bcnt;
  logic [6:0] nx, ny;

  initial begin
    rst = 1'b1; enable = 1'b0; head_x = '0; head_y = '0;
    rst2 = 1'b1; enable2 = 1'b0; head2_x = '0; head2_y = '0;
    step(2);
    check_reset("reset");

    // Running with the head away from food: nothing changes.
    rst = 1'b0; enable = 1'b1;
    seen_add = 1'b0; valid_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      seen_add = seen_add | add_cube;
      valid_ok = valid_ok & (food_valid == 2'b11);
    end
    check("idle_no_add", 32'(seen_add), 32'd0);
    check("idle_valid", 32'(valid_ok), 32'd1);
    check("idle_food_x", 32'(food_x), 32'({7'd28, 7'd24}));
    check("idle_food_y", 32'(food_y), 32'({7'd34, 7'd34}));

    // Head on slot 0 from count 0: pulse after the fourth edge.
    rst = 1'b1; step(1);
    rst = 1'b0; head_x = 7'd24; head_y = 7'd34;
    step(3);
    check("eat_pre_pulse", 32'(add_cube), 32'd0);
    step(1);
    check("eat_pulse", 32'(add_cube), 32'd1);
    check("eat_idx", 32'(eaten_idx), 32'd0);
    check("eat_valid_drop", 32'(food_valid), 32'd2);
    step(1);
    check("eat_pulse_width", 32'(add_cube), 32'd0);
    check("eat_busy", 32'(busy), 32'd1);
    waited = 1;
    while (!food_valid[0] && waited < 130) begin
      step(1);
      waited++;
    end
    check("respawn_in_bound", 32'(food_valid[0]), 32'd1);
    nx = food_x[6:0];
    ny = food_y[6:0];
    check("respawn_in_range", 32'(nx >= 7'd3 && nx <= 7'd60 && ny >= 7'd3 && ny <= 7'd50), 32'd1);
    check("respawn_not_head", 32'(nx == 7'd24 && ny == 7'd34), 32'd0);
    check("respawn_not_slot1", 32'(nx == 7'd28 && ny == 7'd34), 32'd0);
    check("respawn_slot1_kept", 32'(food_x[13:7]), 32'd28);

    // Enable low freezes the counter at 2 with the head on food.
    rst = 1'b1; step(1);
    rst = 1'b0; enable = 1'b1; head_x = 7'd0; head_y = 7'd0;
    step(2);
    enable = 1'b0; head_x = 7'd24; head_y = 7'd34;
    seen_add = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      seen_add = seen_add | add_cube;
    end
    check("freeze_no_add", 32'(seen_add), 32'd0);
    check("freeze_valid", 32'(food_valid), 32'd3);
    enable = 1'b1;
    step(1);
    check("resume_early", 32'(add_cube), 32'd0);
    step(1);
    check("resume_pulse", 32'(add_cube), 32'd1);

    // Reset while the sequencer is drawing.
    step(1);
    check("draw_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step(1);
    check_reset("mid_reset");
    rst = 1'b0; enable = 1'b0; head_x = 7'd0; head_y = 7'd0;

    // Single-cell playfield occupied by the head forces the fallback.
    rst2 = 1'b0; enable2 = 1'b1; head2_x = 7'd24; head2_y = 7'd34;
    step(4);
    check("fb_pulse", 32'(add2_cube), 32'd1);
    check("fb_idx", 32'(eaten2_idx), 32'd0);
    enable2 = 1'b0; head2_x = 7'd5; head2_y = 7'd5;
    bcnt = 0;
    for (int i = 0; i < 400; i++) begin
      step(1);
      if (busy2) bcnt++;
      else if (bcnt > 0) break;
    end
    check("fb_busy_cycles", 32'(bcnt), 32'd130);
    check("fb_x", 32'(food2_x[6:0]), 32'd5);
    check("fb_y", 32'(food2_y[6:0]), 32'd5);
    check("fb_valid", 32'(food2_valid), 32'd3);
    check("fb_slot1_x", 32'(food2_x[13:7]), 32'd28);

`ifdef FOOD_TIMEOUT_EN
    // Uneaten food relocates after 1023 ticks without a grow pulse.
    rst = 1'b1; step(1);
    rst = 1'b0; enable = 1'b1; head_x = 7'd0; head_y = 7'd0;
    seen_add = 1'b0; waited = 0;
    while (food_valid == 2'b11 && waited < 5000) begin
      step(1);
      waited++;
      seen_add = seen_add | add_cube;
    end
    check("timeout_drop", 32'(food_valid != 2'b11), 32'd1);
    waited = 0;
    while (food_valid != 2'b11 && waited < 400) begin
      step(1);
      waited++;
      seen_add = seen_add | add_cube;
    end
    check("timeout_return", 32'(food_valid), 32'd3);
    check("timeout_no_add", 32'(seen_add), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
